fft_frame_loader: RTL and testbench
===================================

// Module: fft_frame_loader
// PURPOSE
// - Upstream feeder for the radix-4 butterfly stage: collects N real audio samples,
//   packs each as complex {real, 16'h0}, stores them in base-4 digit-reversed order,
//   then streams groups of four (a,b,c,d) to the first butterfly stage.
// - Frame-based: fill a frame, then drain it as N/4 groups with a valid/ready handshake.
// PARAMETERS
// - WIDTH     32  packed complex word width: real in [WIDTH-1:WIDTH/2], imag in [WIDTH/2-1:0]
// - SAMPLE_W  16  input sample width; must equal WIDTH/2
// - N_POINTS  16  frame length; power of 4, >= 4
// PORTS
// - clk           in   1                 system clock, all logic on rising edge
// - rst_n         in   1                 synchronous active-low reset
// - sample_in     in   SAMPLE_W          signed audio sample
// - sample_valid  in   1                 sample_in valid
// - sample_ready  out  1                 loader accepts a sample this cycle
// - grp_a..grp_d  out  WIDTH (each)      four packed complex words for one butterfly
// - grp_index     out  log2(N_POINTS/4)  group number within the frame, 0..N/4-1
// - grp_valid     out  1                 group outputs valid
// - grp_ready     in   1                 downstream consumes the group
// - frame_start   out  1                 high with grp_valid for group 0
// - frame_last    out  1                 high with grp_valid for group N/4-1
// BEHAVIOUR
// - Interface: one clock, clk; synchronous active-low reset, rst_n.
// - Reset: state=FILL, wr_cnt=0, rd_grp=0, sample_ready=0 during reset and 1 from the
//   first cycle after it, grp_valid=0, frame_start=0, frame_last=0, grp_a..d=0,
//   grp_index=0. Any partial frame is discarded. Memory contents are don't-care.
// - FILL: sample_ready=1. On sample_valid&&sample_ready: mem[digitrev4(wr_cnt)] <=
//   {sample_in, 16'h0}; wr_cnt++. digitrev4 reverses the base-4 digits of the
//   log2(N) bit index. For N=16, 1->4 and 6->9.
// - After the N-th accept: wr_cnt wraps to 0, state->DRAIN the next cycle.
//   sample_ready=0 from that cycle on.
// - DRAIN: registered outputs. grp_valid rises 1 cycle after entering DRAIN with
//   group 0: grp_a..d = mem[4g+0..3].
// - Groups hold stable while grp_valid && !grp_ready. No bubbles are required, but
//   at most 1 idle cycle is allowed between accepted groups.
// - On grp_valid&&grp_ready: rd_grp++. If it was the last group, grp_valid drops the
//   next cycle, rd_grp=0, state->FILL, and sample_ready=1 in that same cycle.
// - grp_ready asserted while grp_valid=0 is ignored. sample_valid during DRAIN is
//   ignored; the upstream source must hold the sample.
// - No arithmetic, saturation or scaling. Samples pass through bit-exact.
// - Reset asserted mid-FILL or mid-DRAIN: reset values apply on that edge and the
//   frame is abandoned.
// CONFIGURATION
// - FRAME_LOADER_PINGPONG_EN defined: two memory banks.
//   - FILL writes bank X while DRAIN reads bank Y at the same time.
//   - sample_ready=1 whenever the fill bank is not full.
//   - A full fill bank waits until the drain of the other bank completes, then banks
//     swap. grp_valid rises 1 cycle after the swap.
//   - If a drain finishes and the other bank is not full, grp_valid stays 0.
//   - Sustained throughput: one sample per cycle when grp_ready is held high.
// - Not defined: single bank. FILL and DRAIN are mutually exclusive as above.
// TESTING
// - N=16; feed samples k=0..15 (value k) back-to-back, grp_ready=1 -> groups
//   {0,4,8,12}, {1,5,9,13}, {2,6,10,14}, {3,7,11,15} in real halves, imag halves=0.
//   frame_start on group 0, frame_last on group 3.
// - Hold grp_ready=0 for 5 cycles on group 1 -> outputs and grp_index=1 stay stable.
//   After release, groups 2 and 3 follow.
// - Negative samples: 16'h8000 and 16'hFFFF -> real halves bit-exact, imag=16'h0000.
// - Toggle sample_valid 1-0-1, then assert it during DRAIN -> no DRAIN-phase sample is
//   written; sample_ready=0 throughout DRAIN; the next frame starts clean.
// - Pull rst_n low after 9 of 16 samples -> grp_valid never rises. The next 16
//   samples form a correct frame with frame_start on its group 0.
// - PINGPONG_EN, continuous input, grp_ready=1 -> sample_ready never drops after the
//   first frame. Frames 1 and 2 both drain correctly with no data mixing.

Source files
------------

// File: rtl/fft_frame_loader_if.sv
// fft_frame_loader_if: sample-in and butterfly-group-out stream signals of the frame loader.
//   sample_in/sample_valid/sample_ready : real audio sample stream into the loader
//   grp_a..grp_d                        : four packed complex words {real, imag} of one group
//   grp_index                           : group number within the frame
//   grp_valid/grp_ready                 : group handshake towards the butterfly stage
//   frame_start/frame_last              : flags accompanying the first and the last group
// Modports: slave = the loader itself, master = the surrounding source/sink.
interface fft_frame_loader_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned N_POINTS = 16
);
    localparam int unsigned GrpW = (N_POINTS / 4 > 1) ? $clog2(N_POINTS / 4) : 1;

    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic                sample_ready;
    logic [WIDTH-1:0]    grp_a;
    logic [WIDTH-1:0]    grp_b;
    logic [WIDTH-1:0]    grp_c;
    logic [WIDTH-1:0]    grp_d;
    logic [GrpW-1:0]     grp_index;
    logic                grp_valid;
    logic                grp_ready;
    logic                frame_start;
    logic                frame_last;

    modport slave (
        input  sample_in, sample_valid, grp_ready,
        output sample_ready, grp_a, grp_b, grp_c, grp_d, grp_index, grp_valid,
               frame_start, frame_last
    );

    modport master (
        output sample_in, sample_valid, grp_ready,
        input  sample_ready, grp_a, grp_b, grp_c, grp_d, grp_index, grp_valid,
               frame_start, frame_last
    );
endinterface

// File: rtl/fft_frame_loader.sv
// fft_frame_loader: collects N_POINTS real samples into a frame stored in base-4 digit-reversed
// order (imag half zero), then streams N_POINTS/4 groups of four packed complex words to the
// first radix-4 butterfly stage.
// Ports:
//   clk   : clock, everything on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : fft_frame_loader_if.slave (sample stream in, group stream out)
// Build option: define FRAME_LOADER_PINGPONG_EN for two banks, so one frame fills while the
// previous one drains. Without it a single bank alternates between filling and draining.
module fft_frame_loader #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned N_POINTS = 16
) (
    input logic               clk,
    input logic               rst_n,
    fft_frame_loader_if.slave bus
);
    localparam int unsigned AddrW = $clog2(N_POINTS);
    localparam int unsigned NGrp  = N_POINTS / 4;
    localparam int unsigned GrpW  = (NGrp > 1) ? $clog2(NGrp) : 1;
    localparam int unsigned PadW  = WIDTH - SAMPLE_W;
`ifdef FRAME_LOADER_PINGPONG_EN
    localparam int unsigned NBanks = 2;
`else
    localparam int unsigned NBanks = 1;
`endif
    localparam int unsigned MemAw = $clog2(NBanks * N_POINTS);

    typedef enum logic {StFill, StDrain} state_e;
    state_e state_q, state_d;

    // Only the real half is stored; the imag half is always zero on output.
    logic [SAMPLE_W-1:0] mem_q [NBanks*N_POINTS];
    logic [SAMPLE_W-1:0] rd_word [4];
    logic [AddrW-1:0]    wr_cnt_q;
    logic [MemAw-1:0]    wr_addr;
    logic                rd_bank;
    logic [GrpW-1:0]     rd_grp_q, rd_grp_d, grp_sel;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;
    logic [WIDTH-1:0]    grp_q [4];
    logic [GrpW-1:0]     idx_q;
    logic                start_q, last_q;
    logic                accept, fill_done, grp_hs, grp_hs_last, swap, load;

    // Reverse the base-4 digits (bit pairs) of a sample index.
    function automatic logic [AddrW-1:0] digit_rev(input logic [AddrW-1:0] idx);
        logic [AddrW-1:0] rev;
        rev = '0;
        for (int i = 0; i < AddrW / 2; i++) begin
            rev[2*i]   = idx[AddrW-2-2*i];
            rev[2*i+1] = idx[AddrW-1-2*i];
        end
        return rev;
    endfunction

    assign accept      = ready_q && bus.sample_valid;
    assign fill_done   = accept && (wr_cnt_q == AddrW'(N_POINTS - 1));
    assign grp_hs      = valid_q && bus.grp_ready;
    assign grp_hs_last = grp_hs && (rd_grp_q == GrpW'(NGrp - 1));

`ifdef FRAME_LOADER_PINGPONG_EN
    logic fill_bank_q, fill_full_q, full_now;

    // A full fill bank swaps over as soon as the drain side is idle or finishing this cycle.
    assign full_now = fill_full_q || fill_done;
    assign swap     = full_now && ((state_q == StFill) || grp_hs_last);
    assign wr_addr  = {fill_bank_q, digit_rev(wr_cnt_q)};
    assign rd_bank  = !fill_bank_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_bank_q <= 1'b0;
            fill_full_q <= 1'b0;
        end else begin
            fill_bank_q <= fill_bank_q ^ swap;
            fill_full_q <= full_now && !swap;
        end
    end
`else
    assign swap    = fill_done;
    assign wr_addr = digit_rev(wr_cnt_q);
    assign rd_bank = 1'b0;
`endif

    // While a group is on the outputs the next one is prefetched for a bubble-free advance.
    assign grp_sel = valid_q ? rd_grp_q + GrpW'(1) : rd_grp_q;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rd_word[k] = mem_q[MemAw'(32'(N_POINTS) * 32'(rd_bank) + 32'd4 * 32'(grp_sel)
                                      + 32'(k))];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a swap landing on the last handshake keeps the drain side busy.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill:  if (swap) state_d = StDrain;
            StDrain: if (grp_hs_last && !swap) state_d = StFill;
        endcase
    end

    // FSM outputs: group load/advance control and the next sample_ready.
    always_comb begin
        load     = 1'b0;
        valid_d  = valid_q;
        rd_grp_d = rd_grp_q;
        if (state_q == StDrain) begin
            if (!valid_q) begin
                load    = 1'b1;
                valid_d = 1'b1;
            end else if (grp_hs_last) begin
                valid_d  = 1'b0;
                rd_grp_d = '0;
            end else if (grp_hs) begin
                load     = 1'b1;
                rd_grp_d = grp_sel;
            end
        end
`ifdef FRAME_LOADER_PINGPONG_EN
        ready_d = !(full_now && !swap);
`else
        ready_d = (state_d == StFill);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
            rd_grp_q <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            start_q  <= 1'b0;
            last_q   <= 1'b0;
            for (int k = 0; k < 4; k++) grp_q[k] <= '0;
        end else begin
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            rd_grp_q <= rd_grp_d;
            if (accept) wr_cnt_q <= wr_cnt_q + AddrW'(1);
            if (load) begin
                for (int k = 0; k < 4; k++) grp_q[k] <= {rd_word[k], {PadW{1'b0}}};
                idx_q   <= grp_sel;
                start_q <= (grp_sel == '0);
                last_q  <= (grp_sel == GrpW'(NGrp - 1));
            end else if (grp_hs_last) begin
                start_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    // Frame storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (rst_n && accept) mem_q[wr_addr] <= bus.sample_in;
    end

    assign bus.sample_ready = ready_q;
    assign bus.grp_valid    = valid_q;
    assign bus.grp_a        = grp_q[0];
    assign bus.grp_b        = grp_q[1];
    assign bus.grp_c        = grp_q[2];
    assign bus.grp_d        = grp_q[3];
    assign bus.grp_index    = idx_q;
    assign bus.frame_start  = start_q;
    assign bus.frame_last   = last_q;
endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader: randomized self-checking bench for fft_frame_loader (N_POINTS = 16).
// A frame-level reference model turns every 16 accepted samples into the expected group list
// and predicts sample_ready from how many frames are queued for draining.
module tb_fft_frame_loader;
    localparam int unsigned WIDTH    = 32;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned N_POINTS = 16;
    localparam int unsigned NGrp     = N_POINTS / 4;
    localparam int unsigned NDigits  = $clog2(N_POINTS) / 2;

    typedef struct packed {
        logic [31:0] a, b, c, d;
        logic [7:0]  idx;
    } grp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fft_frame_loader_if #(.WIDTH(WIDTH), .SAMPLE_W(SAMPLE_W), .N_POINTS(N_POINTS)) bus ();

    fft_frame_loader #(.WIDTH(WIDTH), .SAMPLE_W(SAMPLE_W), .N_POINTS(N_POINTS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] fill_q[$];
    grp_t        exp_q[$];   // frame currently draining
    grp_t        pend_q[$];  // full frame waiting for the drain side (two-bank build only)
    bit          rst_seen_high = 1'b0;
    int unsigned wait_cnt = 0;
    bit          stall_prev = 1'b0;
    bit          pp_meas = 1'b0;
    int unsigned pp_drops = 0;

    // Sample index whose base-4 digits are those of i reversed.
    function automatic int unsigned digit_rev(input int unsigned i);
        int unsigned r = 0;
        int unsigned v = i;
        for (int d = 0; d < NDigits; d++) begin
            r = r * 4 + v % 4;
            v = v / 4;
        end
        return r;
    endfunction

    function automatic bit model_ready();
`ifdef FRAME_LOADER_PINGPONG_EN
        return rst_seen_high && (pend_q.size() == 0);
`else
        return rst_seen_high && (exp_q.size() == 0);
`endif
    endfunction

    always @(posedge clk) begin
        bit   rdy;
        bit   to_pend;
        grp_t g;
        rdy = model_ready();
        if (!rst_n) begin
            fill_q.delete();
            exp_q.delete();
            pend_q.delete();
            rst_seen_high = 1'b0;
        end else begin
            if (bus.grp_valid && bus.grp_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0 && pend_q.size() != 0) begin
                    exp_q = pend_q;
                    pend_q.delete();
                end
            end
            if (rdy && bus.sample_valid) begin
                fill_q.push_back(bus.sample_in);
                if (fill_q.size() == N_POINTS) begin
                    to_pend = (exp_q.size() != 0);
                    for (int gi = 0; gi < NGrp; gi++) begin
                        g.a   = {fill_q[digit_rev(4 * gi + 0)], 16'h0000};
                        g.b   = {fill_q[digit_rev(4 * gi + 1)], 16'h0000};
                        g.c   = {fill_q[digit_rev(4 * gi + 2)], 16'h0000};
                        g.d   = {fill_q[digit_rev(4 * gi + 3)], 16'h0000};
                        g.idx = 8'(gi);
                        if (to_pend) pend_q.push_back(g);
                        else exp_q.push_back(g);
                    end
                    fill_q.delete();
                end
            end
            rst_seen_high = 1'b1;
        end
    end

    // ---------------- output checks, away from the active edge ----------------
    always @(negedge clk) begin
        if (!rst_seen_high) begin
            check_eq("rst_sample_ready", 32'(bus.sample_ready), 0);
            check_eq("rst_grp_valid", 32'(bus.grp_valid), 0);
            check_eq("rst_frame_start", 32'(bus.frame_start), 0);
            check_eq("rst_frame_last", 32'(bus.frame_last), 0);
            check_eq("rst_grp_index", 32'(bus.grp_index), 0);
            check_eq("rst_grp_a", bus.grp_a, 0);
            check_eq("rst_grp_d", bus.grp_d, 0);
            wait_cnt   = 0;
            stall_prev = 1'b0;
        end else begin
            check_eq("sample_ready", 32'(bus.sample_ready), 32'(model_ready()));
            if (stall_prev) check_eq("grp_hold_valid", 32'(bus.grp_valid), 1);
            if (exp_q.size() == 0) begin
                check_eq("grp_valid_idle", 32'(bus.grp_valid), 0);
                wait_cnt = 0;
            end else if (!bus.grp_valid) begin
                wait_cnt++;
                check_eq("grp_valid_late", 32'(wait_cnt > 1), 0);
            end else begin
                wait_cnt = 0;
                check_eq("grp_a", bus.grp_a, exp_q[0].a);
                check_eq("grp_b", bus.grp_b, exp_q[0].b);
                check_eq("grp_c", bus.grp_c, exp_q[0].c);
                check_eq("grp_d", bus.grp_d, exp_q[0].d);
                check_eq("grp_index", 32'(bus.grp_index), 32'(exp_q[0].idx));
                check_eq("frame_start", 32'(bus.frame_start), 32'(exp_q[0].idx == 0));
                check_eq("frame_last", 32'(bus.frame_last), 32'(exp_q[0].idx == NGrp - 1));
            end
            if (!bus.grp_valid) begin
                check_eq("frame_start_idle", 32'(bus.frame_start), 0);
                check_eq("frame_last_idle", 32'(bus.frame_last), 0);
            end
            stall_prev = bus.grp_valid && !bus.grp_ready;
        end
        if (pp_meas && !bus.sample_ready) pp_drops++;
    end

    // ---------------- grp_ready driver ----------------
    int rdy_mode  = 0;  // 0: always ready, 1: random, 2: stall group 1 for five cycles
    int stall_cnt = 0;

    initial bus.grp_ready = 1'b1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: bus.grp_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (bus.grp_valid && bus.grp_index == 1 && stall_cnt < 5) begin
                    bus.grp_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    bus.grp_ready = 1'b1;
                end
            end
            default: bus.grp_ready = 1'b1;
        endcase
    end

    // ---------------- stimulus tasks (start and end just after a rising edge) ----------------
    task automatic send_sample(input logic [15:0] v, input int unsigned gap);
        bit acc = 1'b0;
        if (gap != 0) begin
            bus.sample_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        bus.sample_in    = v;
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge clk);
            acc = bus.sample_ready;
            @(posedge clk);
            #1;
        end
        check_eq("sample_accept", 32'(acc), 1);
    endtask

    task automatic feed_random(input int unsigned n, input int unsigned max_gap);
        for (int i = 0; i < n; i++) send_sample(16'($urandom), $urandom_range(0, max_gap));
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk);
            #1;
            done = (exp_q.size() == 0) && (pend_q.size() == 0) && (fill_q.size() == 0);
        end
        check_eq("drain_done", 32'(done), 1);
    endtask

    task automatic apply_reset(input int unsigned cycles);
        rst_n            = 1'b0;
        bus.sample_valid = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit seen;
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Ramp 0..15 back-to-back, downstream always ready.
        for (int i = 0; i < 16; i++) send_sample(16'(i), 0);
        bus.sample_valid = 1'b0;
        wait_drain();

        // Stall group 1 for five cycles.
        stall_cnt = 0;
        rdy_mode  = 2;
        feed_random(16, 0);
        bus.sample_valid = 1'b0;
        wait_drain();
        check_eq("stall_cycles", 32'(stall_cnt), 5);

        // Negative / extreme samples pass bit-exact, random backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0: send_sample(16'h8000, 0);
                1: send_sample(16'hFFFF, 0);
                2: send_sample(16'h7FFF, 0);
                default: send_sample(16'($urandom), 0);
            endcase
        end
        bus.sample_valid = 1'b0;
        wait_drain();

        // valid toggles 1-0-1, then stays asserted through the drain of this frame.
        send_sample(16'h1111, 0);
        send_sample(16'h2222, 1);
        feed_random(14, 2);
        send_sample(16'hDEAD, 0);
        feed_random(15, 1);
        bus.sample_valid = 1'b0;
        wait_drain();

        // Reset after 9 of 16 samples abandons the partial frame.
        feed_random(9, 1);
        apply_reset(2);
        feed_random(16, 1);
        bus.sample_valid = 1'b0;
        wait_drain();

        // Reset in the middle of a drain.
        rdy_mode = 0;
        feed_random(16, 0);
        bus.sample_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.grp_valid;
        end
        check_eq("drain_started", 32'(seen), 1);
        @(posedge clk);
        #1;
        apply_reset(2);
        rdy_mode = 1;
        feed_random(16, 0);
        bus.sample_valid = 1'b0;
        wait_drain();

        // Several random frames with random gaps and backpressure.
        feed_random(48, 2);
        bus.sample_valid = 1'b0;
        wait_drain();

`ifdef FRAME_LOADER_PINGPONG_EN
        // Continuous input with an always-ready sink must never stall the source.
        rdy_mode = 0;
        feed_random(16, 0);
        pp_drops = 0;
        pp_meas  = 1'b1;
        feed_random(32, 0);
        pp_meas          = 1'b0;
        bus.sample_valid = 1'b0;
        wait_drain();
        check_eq("pp_ready_drops", pp_drops, 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
